// File: rtl/ps2_kbd.sv
// ps2_kbd: PS/2 keyboard receiver for the BlockFall sequencer bus.
// Deserialises device-to-host PS/2 frames (start, 8 data LSB-first, odd
// parity, stop) and queues good scan codes in a small circular FIFO that
// the sequencer drains one byte per RDC instruction.
//
// Ports:
//   clock    system clock, all state changes on its rising edge
//   reset    asynchronous active-low reset
//   inst     instruction, [11:8] opcode (0 NOP, 1 RDC, 2 CLR), [7:0] unused
//   inst_en  instruction valid this cycle
//   ps2_clk  raw PS/2 clock pin (asynchronous)
//   ps2_data raw PS/2 data pin (asynchronous)
//   data     last scan code popped by RDC
//   status   {5'h0, overflow, parity_err, ready}
module ps2_kbd #(
  parameter int          FIFO_LOG2 = 2,
  parameter logic [15:0] TIMEOUT   = 16'd10000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        inst_en,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [7:0]  data,
  output logic [7:0]  status
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW    = FIFO_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // A frame is good when the data bits plus the parity bit have odd weight.
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic ps2_data_p0, ps2_data_p1;
  logic fe;

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [15:0]   to_cnt;
  logic          timed_out;
  logic          push_req, perr_req;

  logic [7:0]           mem [DEPTH];
  logic [FIFO_LOG2-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0]        count;
  logic                 overflow, parity_err;
  logic                 rdc, clr, pop, full, do_push;
  logic                 unused_inst;

  assign unused_inst = ^inst[7:0];

  // Stage p0/p1: two-flop synchronisers; p2 keeps the previous clock level.
  // Flops idle high so reset looks like a quiet bus.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_clk_p2  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= ps2_clk;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_clk_p2  <= ps2_clk_p1;
      ps2_data_p0 <= ps2_data;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  assign fe = ps2_clk_p2 & ~ps2_clk_p1;

  // An edge in the same cycle as the limit keeps the frame alive.
  assign timed_out = (state != S_IDLE) && (to_cnt == TIMEOUT) && !fe;

  // Receive FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      bit_cnt <= 3'd0;
      to_cnt  <= 16'd0;
    end else begin
      state <= state_nxt;
      if (fe && state == S_IDLE)      bit_cnt <= 3'd0;
      else if (fe && state == S_DATA) bit_cnt <= bit_cnt + 3'd1;
      if (fe || state == S_IDLE || timed_out) to_cnt <= 16'd0;
      else                                    to_cnt <= to_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    perr_req  = 1'b0;
    if (timed_out) begin
      state_nxt = S_IDLE;
    end else if (fe) begin
      case (state)
        S_IDLE:   if (!ps2_data_p1) state_nxt = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        S_STOP: begin
          state_nxt = S_IDLE;
          // A missing stop bit drops the frame without raising a flag.
          if (ps2_data_p1) begin
            if (odd_parity_ok(shift, par_bit)) push_req = 1'b1;
            else                               perr_req = 1'b1;
          end
        end
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame datapath: no reset, contents only matter once a frame completes.
  always_ff @(posedge clock) begin
    if (fe && state == S_DATA)   shift   <= {ps2_data_p1, shift[7:1]};
    if (fe && state == S_PARITY) par_bit <= ps2_data_p1;
  end

  // FIFO and instruction handling
  assign rdc  = inst_en && (inst[11:8] == 4'h1);
  assign clr  = inst_en && (inst[11:8] == 4'h2);
  assign pop  = rdc && (count != '0);
  assign full = (count == CW'(DEPTH));
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign do_push = push_req && !clr && (!full || pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      data       <= 8'h00;
    end else if (clr) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (pop) begin
        data   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(pop);
      if (push_req && !do_push) overflow   <= 1'b1;
      if (perr_req)             parity_err <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  assign status = {5'h00, overflow, parity_err, (count != '0)};

endmodule

// File: tb/tb_ps2_kbd.sv
// Testbench for ps2_kbd: drives PS/2 frames bit by bit and compares the
// data/status outputs against a queue-based model of the receiver.
module tb_ps2_kbd;

  localparam int          HALF = 20;        // PS/2 half bit period in clocks
  localparam logic [15:0] TO   = 16'd200;

  logic        clock    = 1'b0;
  logic        reset    = 1'b0;
  logic [11:0] inst     = 12'h000;
  logic        inst_en  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [7:0]  data;
  logic [7:0]  status;

  int errors = 0;
  int checks = 0;

  // Reference model state
  byte unsigned mq[$];
  logic [7:0]   m_data = 8'h00;
  bit           m_ovf  = 1'b0;
  bit           m_perr = 1'b0;

  always #5 clock = ~clock;

  ps2_kbd #(.FIFO_LOG2(2), .TIMEOUT(TO)) dut (
    .clock    (clock),
    .reset    (reset),
    .inst     (inst),
    .inst_en  (inst_en),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data     (data),
    .status   (status)
  );

  function automatic logic [7:0] exp_status();
    return {5'h00, m_ovf, m_perr, (mq.size() != 0)};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ovf  = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic model_rdc();
    if (mq.size() != 0) m_data = mq.pop_front();
  endtask

  task automatic model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                             input bit with_rdc, input bit with_clr);
    if (with_clr) begin
      model_clear();
    end else begin
      if (with_rdc) model_rdc();
      if (!stop_bad) begin
        if (par_bad)              m_perr = 1'b1;
        else if (mq.size() < 4)   mq.push_back(b);
        else                      m_ovf = 1'b1;
      end
    end
  endtask

  // One PS/2 bit; optionally issues an instruction on the exact cycle the
  // receiver acts on this bit's falling edge.
  task automatic ps2_bit(input bit b, input bit fire, input logic [3:0] op);
    @(negedge clock) ps2_data = b;
    repeat (HALF - 1) @(negedge clock);
    ps2_clk = 1'b0;
    if (fire) begin
      @(negedge clock);
      @(negedge clock);
      inst    = {op, 8'($urandom_range(0, 255))};
      inst_en = 1'b1;
      @(negedge clock);
      inst_en = 1'b0;
      inst    = 12'h000;
      repeat (HALF - 3) @(negedge clock);
    end else begin
      repeat (HALF) @(negedge clock);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                            input bit fire, input logic [3:0] op);
    logic par;
    par = (~^b) ^ par_bad;
    ps2_bit(1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0, 4'h0);
    ps2_bit(par, 1'b0, 4'h0);
    ps2_bit(!stop_bad, fire, op);
    @(negedge clock) ps2_data = 1'b1;
    repeat (4) @(negedge clock);
    model_frame(b, par_bad, stop_bad, fire && (op == 4'h1), fire && (op == 4'h2));
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic send_partial(input int nbits, input logic [7:0] b);
    ps2_bit(1'b0, 1'b0, 4'h0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0, 4'h0);
    @(negedge clock) ps2_data = 1'b1;
  endtask

  // Drives one instruction for one cycle; outputs are settled on return.
  task automatic do_inst(input logic [3:0] op, input bit en);
    @(negedge clock);
    inst    = {op, 8'($urandom_range(0, 255))};
    inst_en = en;
    @(negedge clock);
    inst_en = 1'b0;
    inst    = 12'h000;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h expected %h", data, 8'h00);
    end
    checks++;
    if (status !== 8'h00) begin
      errors++; $display("FAIL reset_status: got %h expected %h", status, 8'h00);
    end
    reset = 1'b1;
    model_clear();
    m_data = 8'h00;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_single_frame();
    send_good(8'h1C);
    checks++;
    if (status !== 8'h01) begin
      errors++; $display("FAIL single_status: got %h expected %h", status, 8'h01);
    end
    do_inst(4'h1, 1'b1); model_rdc();
    checks++;
    if (data !== 8'h1C) begin
      errors++; $display("FAIL single_data: got %h expected %h", data, 8'h1C);
    end
    checks++;
    if (status !== 8'h00) begin
      errors++; $display("FAIL single_status_after: got %h expected %h", status, 8'h00);
    end
  endtask

  task automatic test_parity_error();
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 4'h0);
    checks++;
    if (status !== 8'h02) begin
      errors++; $display("FAIL parity_status: got %h expected %h", status, 8'h02);
    end
    do_inst(4'h2, 1'b1); model_clear();
    checks++;
    if (status !== 8'h00) begin
      errors++; $display("FAIL parity_clr: got %h expected %h", status, 8'h00);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) send_good(8'(i));
    checks++;
    if (status !== 8'h05) begin
      errors++; $display("FAIL ovf_status: got %h expected %h", status, 8'h05);
    end
    for (int i = 1; i <= 5; i++) begin
      do_inst(4'h1, 1'b1); model_rdc();
      checks++;
      if (data !== m_data) begin
        errors++; $display("FAIL ovf_rdc%0d_data: got %h expected %h", i, data, m_data);
      end
      checks++;
      if (status !== exp_status()) begin
        errors++; $display("FAIL ovf_rdc%0d_status: got %h expected %h", i, status, exp_status());
      end
    end
    checks++;
    if (data !== 8'h04 || status !== 8'h04) begin
      errors++; $display("FAIL ovf_final: got data %h status %h expected 04 04", data, status);
    end
    do_inst(4'h2, 1'b1); model_clear();
    checks++;
    if (status !== 8'h00) begin
      errors++; $display("FAIL ovf_clr: got %h expected %h", status, 8'h00);
    end
  endtask

  task automatic test_wrap();
    for (int it = 0; it < 22; it++) begin
      if (mq.size() == 4 || (mq.size() != 0 && $urandom_range(0, 2) == 0)) begin
        do_inst(4'h1, 1'b1); model_rdc();
      end else begin
        send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), 1'b0, 1'b0, 4'h0);
      end
      checks++;
      if (data !== m_data || status !== exp_status()) begin
        errors++;
        $display("FAIL wrap_step%0d: got data %h status %h expected data %h status %h",
                 it, data, status, m_data, exp_status());
      end
    end
    while (mq.size() != 0) begin
      do_inst(4'h1, 1'b1); model_rdc();
      checks++;
      if (data !== m_data) begin
        errors++; $display("FAIL wrap_drain: got %h expected %h", data, m_data);
      end
    end
    do_inst(4'h2, 1'b1); model_clear();
    checks++;
    if (status !== 8'h00) begin
      errors++; $display("FAIL wrap_clr: got %h expected %h", status, 8'h00);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) send_good(8'($urandom_range(0, 255)));
    checks++;
    if (status !== 8'h01) begin
      errors++; $display("FAIL simul_full: got %h expected %h", status, 8'h01);
    end
    send_frame(8'hB7, 1'b0, 1'b0, 1'b1, 4'h1);
    checks++;
    if (status !== exp_status() || status[2] !== 1'b0) begin
      errors++; $display("FAIL simul_rdc_push_status: got %h expected %h", status, exp_status());
    end
    checks++;
    if (data !== m_data) begin
      errors++; $display("FAIL simul_rdc_push_data: got %h expected %h", data, m_data);
    end
    for (int i = 0; i < 4; i++) begin
      do_inst(4'h1, 1'b1); model_rdc();
      checks++;
      if (data !== m_data || status !== exp_status()) begin
        errors++;
        $display("FAIL simul_drain%0d: got data %h status %h expected data %h status %h",
                 i, data, status, m_data, exp_status());
      end
    end
    // CLR landing on the push cycle discards the incoming byte.
    send_good(8'h42);
    send_frame(8'h43, 1'b0, 1'b0, 1'b1, 4'h2);
    checks++;
    if (status !== 8'h00) begin
      errors++; $display("FAIL clr_vs_push: got %h expected %h", status, 8'h00);
    end
    do_inst(4'h1, 1'b1); model_rdc();
    checks++;
    if (data !== m_data) begin
      errors++; $display("FAIL clr_vs_push_data: got %h expected %h", data, m_data);
    end
  endtask

  task automatic test_gating();
    send_good(8'h5B);
    do_inst(4'h1, 1'b0);
    checks++;
    if (data !== m_data || status !== 8'h01) begin
      errors++; $display("FAIL gate_en0: got data %h status %h expected %h 01", data, status, m_data);
    end
    do_inst(4'h7, 1'b1);
    do_inst(4'h0, 1'b1);
    checks++;
    if (data !== m_data || status !== 8'h01) begin
      errors++; $display("FAIL gate_badop: got data %h status %h expected %h 01", data, status, m_data);
    end
    send_frame(8'h12, 1'b0, 1'b1, 1'b0, 4'h0);
    checks++;
    if (status !== 8'h01) begin
      errors++; $display("FAIL gate_nostop: got %h expected %h", status, 8'h01);
    end
    do_inst(4'h1, 1'b1); model_rdc();
    checks++;
    if (data !== 8'h5B || status !== 8'h00) begin
      errors++; $display("FAIL gate_rdc: got data %h status %h expected 5b 00", data, status);
    end
    do_inst(4'h1, 1'b1); model_rdc();
    checks++;
    if (data !== 8'h5B || status !== 8'h00) begin
      errors++; $display("FAIL gate_rdc_empty: got data %h status %h expected 5b 00", data, status);
    end
  endtask

  task automatic test_timeout();
    send_partial(3, 8'h55);
    repeat (int'(TO) + 50) @(negedge clock);
    send_good(8'hF0);
    checks++;
    if (status !== 8'h01) begin
      errors++; $display("FAIL timeout_status: got %h expected %h", status, 8'h01);
    end
    do_inst(4'h1, 1'b1); model_rdc();
    checks++;
    if (data !== 8'hF0 || status !== 8'h00) begin
      errors++; $display("FAIL timeout_data: got data %h status %h expected f0 00", data, status);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_good(8'h3C);
    send_good(8'h77);
    do_inst(4'h1, 1'b1); model_rdc();
    send_frame(8'h10, 1'b1, 1'b0, 1'b0, 4'h0);
    checks++;
    if (data !== 8'h3C || status !== 8'h03) begin
      errors++; $display("FAIL pre_reset: got data %h status %h expected 3c 03", data, status);
    end
    send_partial(4, 8'hAA);
    @(negedge clock);
    reset = 1'b0;
    #1;
    model_clear();
    m_data = 8'h00;
    checks++;
    if (data !== 8'h00 || status !== 8'h00) begin
      errors++; $display("FAIL midreset_outputs: got data %h status %h expected 00 00", data, status);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    send_good(8'hAA);
    checks++;
    if (status !== 8'h01) begin
      errors++; $display("FAIL midreset_status: got %h expected %h", status, 8'h01);
    end
    do_inst(4'h1, 1'b1); model_rdc();
    checks++;
    if (data !== 8'hAA || status !== 8'h00) begin
      errors++; $display("FAIL midreset_data: got data %h status %h expected aa 00", data, status);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity_error();
    test_overflow();
    test_wrap();
    test_simultaneous();
    test_gating();
    test_timeout();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
